// File: rtl/pb_loader_pkg.sv
// Shared definitions for the push-button operand loader: slice widths,
// button-to-slice assignment, FSM state encoding and a small helper.
package pb_loader_pkg;

  // Default operand width and the high/low slice split derived from it.
  localparam int WIDTH_DEFAULT = 7;
  localparam int HI_W          = 4;
  localparam int LO_W          = WIDTH_DEFAULT - HI_W;

  // Which button loads which operand slice.
  localparam int PB_A_HI = 0;
  localparam int PB_A_LO = 1;
  localparam int PB_B_HI = 2;
  localparam int PB_B_LO = 3;

  localparam int NUM_PB = 4;

  // COLLECT gathers slices, PRESENT offers the finished pair downstream.
  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } loader_state_t;

  // True once every slice has been loaded at least once since the last handshake.
  function automatic logic all_loaded(input logic [NUM_PB-1:0] flags);
    return &flags;
  endfunction

endpackage

// File: rtl/pb_operand_loader_debounce.sv
// Per-button conditioning: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle pulse on the debounced rising edge.
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_raw,
  output logic level,
  output logic press
);

  // Counter must be able to hold DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          level_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pb_raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 != level) begin
      if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  // Only presses (0->1) produce an event; releases are silent.
  assign press = level & ~level_q;

endmodule

// File: rtl/pb_operand_loader.sv
// Builds two WIDTH-bit operands from four debounced buttons and a 4-bit
// switch bank, then offers them to the adder with a valid/ready handshake.
// Optional: define PB_LOADER_STATUS_EN to expose the loaded flags on
// loaded_status for board LEDs.
// WIDTH is expected in the range 5..8 so the low slice fits inside y.
module pb_operand_loader
  import pb_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WIDTH           = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       pb,
  input  logic [3:0]       y,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready
`ifdef PB_LOADER_STATUS_EN
  ,
  output logic [3:0]       loaded_status
`endif
);

  localparam int LW = WIDTH - HI_W;

  logic [NUM_PB-1:0] press;
  logic [NUM_PB-1:0] level;
  logic [NUM_PB-1:0] loaded;
  loader_state_t     state;

  // One conditioning chain per button.
  for (genvar i = 0; i < NUM_PB; i++) begin : g_db
    pb_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .pb_raw(pb[i]),
      .level (level[i]),
      .press (press[i])
    );
  end

  // Collect slices on press events, then hold the pair until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      loaded   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (press[PB_A_HI]) begin
            op_a[WIDTH-1:LW] <= y;
            loaded[PB_A_HI]  <= 1'b1;
          end
          if (press[PB_A_LO]) begin
            op_a[LW-1:0]     <= y[LW-1:0];
            loaded[PB_A_LO]  <= 1'b1;
          end
          if (press[PB_B_HI]) begin
            op_b[WIDTH-1:LW] <= y;
            loaded[PB_B_HI]  <= 1'b1;
          end
          if (press[PB_B_LO]) begin
            op_b[LW-1:0]     <= y[LW-1:0];
            loaded[PB_B_LO]  <= 1'b1;
          end
          if (all_loaded(loaded)) begin
            state    <= PRESENT;
            op_valid <= 1'b1;
          end
        end
        PRESENT: begin
          if (op_valid && op_ready) begin
            state    <= COLLECT;
            op_valid <= 1'b0;
            loaded   <= '0;
          end
        end
        default: begin
          state    <= COLLECT;
          op_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PB_LOADER_STATUS_EN
  assign loaded_status = loaded;
`endif

endmodule

// File: tb/tb_pb_operand_loader.sv
// Directed bench for pb_operand_loader with DEBOUNCE_CYCLES=4, WIDTH=7.
// A clean press becomes a load 7 clocks after it is applied (2 sync +
// 4 debounce + 1 edge), and op_valid follows one clock after the last load.
module tb_pb_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pb;
  logic [3:0] y;
  logic [6:0] op_a;
  logic [6:0] op_b;
  logic       op_valid;
  logic       op_ready;
`ifdef PB_LOADER_STATUS_EN
  logic [3:0] loaded_status;
`endif

  int assertCount = 0;
  int failCount   = 0;

  pb_operand_loader #(
    .DEBOUNCE_CYCLES(4),
    .WIDTH          (7)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pb      (pb),
    .y       (y),
    .op_a    (op_a),
    .op_b    (op_b),
    .op_valid(op_valid),
    .op_ready(op_ready)
`ifdef PB_LOADER_STATUS_EN
    ,
    .loaded_status(loaded_status)
`endif
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input logic [3:0] yval);
    @(negedge clk);
    pb = mask;
    y  = yval;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic releaseButtons();
    @(negedge clk);
    pb = 4'b0000;
    repeat (8) @(posedge clk);
  endtask

  task automatic pressFull(input logic [3:0] mask, input logic [3:0] yval);
    applyStimulus(mask, yval);
    waitEdges(8);
    releaseButtons();
  endtask

  task automatic handshake();
    @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    pb       = 4'b0000;
    y        = 4'b0000;
    op_ready = 1'b0;
    #2;
    checkOutput("reset_op_a", 32'(op_a), 32'h0);
    checkOutput("reset_op_b", 32'(op_b), 32'h0);
    checkOutput("reset_valid", 32'(op_valid), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Happy path
    pressFull(4'b0001, 4'b1101);
    checkOutput("happy_a_hi_only", 32'(op_a), 32'b1101000);
    pressFull(4'b0010, 4'b0101);
    pressFull(4'b0100, 4'b1011);
    checkOutput("happy_valid_before_pb4", 32'(op_valid), 32'h0);
    applyStimulus(4'b1000, 4'b0110);
    waitEdges(7);
    checkOutput("happy_op_b", 32'(op_b), 32'b1011110);
    checkOutput("happy_valid_on_load", 32'(op_valid), 32'h0);
    waitEdges(1);
    checkOutput("happy_valid_after_load", 32'(op_valid), 32'h1);
    checkOutput("happy_op_a", 32'(op_a), 32'b1101101);
`ifdef PB_LOADER_STATUS_EN
    checkOutput("status_all", 32'(loaded_status), 32'hF);
`endif
    releaseButtons();

    // Handshake clears valid and flags, keeps operands
    handshake();
    checkOutput("hs_valid_low", 32'(op_valid), 32'h0);
    checkOutput("hs_op_a_kept", 32'(op_a), 32'b1101101);
    checkOutput("hs_op_b_kept", 32'(op_b), 32'b1011110);
`ifdef PB_LOADER_STATUS_EN
    checkOutput("status_cleared", 32'(loaded_status), 32'h0);
`endif

    // Overwrite, with op_ready high in COLLECT doing nothing
    op_ready = 1'b1;
    pressFull(4'b0010, 4'b0001);
    op_ready = 1'b0;
    checkOutput("ow_first_lo", 32'(op_a), 32'b1101001);
    pressFull(4'b0010, 4'b0111);
    pressFull(4'b0001, 4'b1000);
    pressFull(4'b0100, 4'b0010);
    checkOutput("fresh_set_needed", 32'(op_valid), 32'h0);
    pressFull(4'b1000, 4'b1101);
    checkOutput("ow_valid", 32'(op_valid), 32'h1);
    checkOutput("ow_op_a", 32'(op_a), 32'b1000111);
    checkOutput("ow_op_b", 32'(op_b), 32'b0010101);

    // Press during PRESENT is dropped
    pressFull(4'b0001, 4'b0000);
    checkOutput("hold_op_a", 32'(op_a), 32'b1000111);
    checkOutput("hold_valid", 32'(op_valid), 32'h1);
    handshake();
    checkOutput("hs2_valid_low", 32'(op_valid), 32'h0);

    // Bounce rejection on PB1
    y = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pb[0] = ~pb[0];
    end
    repeat (3) @(negedge clk);
    #1;
    checkOutput("bounce_no_load", 32'(op_a), 32'b1000111);
    applyStimulus(4'b0001, 4'b0011);
    waitEdges(6);
    checkOutput("bounce_not_yet", 32'(op_a[6:3]), 32'b1000);
    waitEdges(1);
    checkOutput("bounce_loaded", 32'(op_a), 32'b0011111);
    checkOutput("bounce_valid", 32'(op_valid), 32'h0);
    releaseButtons();

    // Simultaneous presses on all four buttons
    applyStimulus(4'b1111, 4'b1010);
    waitEdges(7);
    checkOutput("sim_op_a", 32'(op_a), 32'b1010010);
    checkOutput("sim_op_b", 32'(op_b), 32'b1010010);
    checkOutput("sim_valid_on_load", 32'(op_valid), 32'h0);
    waitEdges(1);
    checkOutput("sim_valid", 32'(op_valid), 32'h1);

    // Asynchronous reset in PRESENT
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_op_a", 32'(op_a), 32'h0);
    checkOutput("arst_op_b", 32'(op_b), 32'h0);
    checkOutput("arst_valid", 32'(op_valid), 32'h0);
`ifdef PB_LOADER_STATUS_EN
    checkOutput("arst_status", 32'(loaded_status), 32'h0);
`endif
    pb = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    waitEdges(10);
    checkOutput("post_rst_valid", 32'(op_valid), 32'h0);
    checkOutput("post_rst_op_a", 32'(op_a), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
